seq_detector_moore_param: RTL and testbench
===========================================

Name: seq_detector_moore_param

Overview:
- Parametrised, runtime-programmable successor to the fixed 1011 Moore sequence detector.
- Detects a W-bit pattern, MSB first, on a qualified serial input stream.
- Pattern is reloadable at run time; overlapping or non-overlapping detection is selectable.
- Exposes current_state/next_state for the existing interface-based bench, and optionally counts matches.

Parameters:
- W, 4: pattern length in bits; legal range 2..16.
- DEFAULT_PATTERN, 4'b1011: pattern in force after reset; W bits wide.
- SW, $clog2(W+1): state width (derived; do not override).
- CNT_W, 8: match counter width.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- sequence_valid  in  1  qualifies sequence_in this cycle.
- sequence_in  in  1  serial data bit.
- overlap_en  in  1  1 = overlapping detection; 0 = non-overlapping.
- pattern_load  in  1  one-cycle pulse; loads pattern_in.
- pattern_in  in  W  new pattern, MSB is first bit expected.
- count_clear  in  1  synchronous clear of match_count.
- detector_out  out  1  Moore match output.
- current_state  out  SW  registered state = number of pattern prefix bits currently matched (0..W).
- next_state  out  SW  combinational next state.
- match_count  out  CNT_W  saturating count of matches.

Behaviour:
- Reset (reset=0, asynchronous): state=0, pattern=DEFAULT_PATTERN, match_count=0, detector_out=0.
- Release is synchronised by the caller; the block needs none internally.
- State S is the length of the longest pattern prefix equal to the most recent S accepted bits.
- On a clock edge with sequence_valid=1 and bit b:
  - next S = largest k in [0, L] such that the last k accepted bits, ending with b, equal pattern[W-1:W-k].
  - L = min(S+1, W) when S<W.
  - L = W when S==W and overlap_en=1.
  - L = 1 when S==W and overlap_en=0, so only b is reused and a fresh match restarts.
- Implement the search as a priority compare against a W-bit history shift register, highest k wins.
- With sequence_valid=0: state, history and outputs hold; next_state equals current_state.
- detector_out = (current_state == W), decoded from the state register only (Moore).
  - Rises the cycle after the final pattern bit is sampled.
  - Stays high while sequence_valid=0.
- next_state is always driven, purely combinational from state, history, pattern, sequence_in, sequence_valid and overlap_en.
- pattern_load=1: pattern<=pattern_in, state<=0, history<=0.
  - Takes priority over sequence_valid in the same cycle; that bit is discarded.
  - match_count is unaffected.
- match_count increments by 1 on every clock edge where next_state==W and sequence_valid=1 and pattern_load=0.
  - It saturates at 2^CNT_W-1.
  - count_clear has priority over an increment in the same cycle; the result is 0.
- overlap_en may change at any time; it takes effect from the next accepted bit.
- Pattern of all zeros or all ones is legal; no special casing.
- Reset asserted mid-stream aborts any partial match immediately; no match is reported for bits before reset.

Optional Feature:
- Macro SEQ_DET_MATCH_CNT_EN.
- Defined: match counter and count_clear logic are built as above.
- Undefined: no counter flops; match_count is tied to 0 and count_clear is ignored.
- The port list is identical in both builds.

Test Plan:
- Default pattern 1011, overlap_en=1, bits 1,0,1,1,0,1,1 with sequence_valid=1 → current_state 1,2,3,4,2,3,4; detector_out high after bits 4 and 7; match_count=2.
- Same stream, overlap_en=0 → states 1,2,3,4,0,1,1; detector_out high only after bit 4; match_count=1.
- Load 4'b1111 via pattern_load, then 6 ones:
  - overlap_en=1 → detector_out high 3 consecutive cycles.
  - overlap_en=0 → one match per 4 ones; 8 ones give match_count=2.
- Partial match 1,0,1 (state=3), then sequence_valid=0 for 5 cycles, then 1 → state held at 3, then 4; detector_out asserts.
  - Repeat with reset pulsed low during the idle gap → state 0, the final 1 gives state 1, no match.
- pattern_load together with sequence_valid=1 and a completing bit → no match, state=0, new pattern active.
- count_clear together with a completing match → match_count=0.
- With CNT_W=2, drive 5 matches → match_count saturates at 3.

Source files
------------

// File: rtl/seq_detector_moore_param.sv
// seq_detector_moore_param: runtime-programmable W-bit Moore sequence detector, MSB first.
// Define SEQ_DET_MATCH_CNT_EN to build the saturating match counter; otherwise match_count is 0.
module seq_detector_moore_param #(
    parameter int             W               = 4,
    parameter logic [W-1:0]   DEFAULT_PATTERN = 4'b1011,
    parameter int             SW              = $clog2(W + 1),
    parameter int             CNT_W           = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             sequence_valid,
    input  logic             sequence_in,
    input  logic             overlap_en,
    input  logic             pattern_load,
    input  logic [W-1:0]     pattern_in,
    input  logic             count_clear,
    output logic             detector_out,
    output logic [SW-1:0]    current_state,
    output logic [SW-1:0]    next_state,
    output logic [CNT_W-1:0] match_count
);
    logic [SW-1:0] state_q, state_d, lim, srch;
    logic [W-1:0]  hist_q, hist_d, pat_q, mask;
    // Longest pattern prefix ending at the new bit, capped at lim; later (longer) hits override.
    always_comb begin
        hist_d = {hist_q[W-2:0], sequence_in};
        lim    = (state_q < SW'(W)) ? state_q + 1'b1 : (overlap_en ? SW'(W) : SW'(1));
        srch   = '0;
        mask   = '0;
        for (int k = 1; k <= W; k++) begin
            mask = {W{1'b1}} >> (W - k);
            if (SW'(k) <= lim && ((hist_d ^ (pat_q >> (W - k))) & mask) == '0) srch = SW'(k);
        end
        state_d = sequence_valid ? srch : state_q;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= '0;
            hist_q  <= '0;
            pat_q   <= DEFAULT_PATTERN;
        end else if (pattern_load) begin
            state_q <= '0;
            hist_q  <= '0;
            pat_q   <= pattern_in;
        end else if (sequence_valid) begin
            state_q <= state_d;
            hist_q  <= hist_d;
        end
    end
    assign current_state = state_q;
    assign next_state    = state_d;
    assign detector_out  = (state_q == SW'(W));
`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = count_clear ? '0 :
                        (sequence_valid && !pattern_load && state_d == SW'(W) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign match_count = cnt_q;
`else
    logic unused_count_clear;
    assign unused_count_clear = count_clear;
    assign match_count        = '0;
`endif
endmodule

// File: tb/tb_seq_detector_moore_param.sv
// tb_seq_detector_moore_param: directed plan plus random stream against a bit-queue reference model.
module tb_seq_detector_moore_param;
    localparam int W = 4;
    localparam int SW = $clog2(W + 1);
    localparam logic [W-1:0] DEF = 4'b1011;
`ifdef SEQ_DET_MATCH_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clock = 1'b0, reset = 1'b0;
    logic sequence_valid = 1'b0, sequence_in = 1'b0, overlap_en = 1'b0;
    logic pattern_load = 1'b0, count_clear = 1'b0;
    logic [W-1:0] pattern_in = '0;
    logic detector_out, det2;
    logic [SW-1:0] current_state, next_state, cs2, ns2;
    logic [7:0] match_count;
    logic [1:0] mc2;
    int n_vec = 0, n_err = 0;
    int mq[$];
    int ms = 0, c8 = 0, c2 = 0;
    logic [W-1:0] pat_m = DEF;

    seq_detector_moore_param #(.W(W), .DEFAULT_PATTERN(DEF), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .sequence_valid(sequence_valid), .sequence_in(sequence_in),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .count_clear(count_clear), .detector_out(detector_out), .current_state(current_state),
        .next_state(next_state), .match_count(match_count));

    seq_detector_moore_param #(.W(W), .DEFAULT_PATTERN(DEF), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .sequence_valid(sequence_valid), .sequence_in(sequence_in),
        .overlap_en(overlap_en), .pattern_load(pattern_load), .pattern_in(pattern_in),
        .count_clear(count_clear), .detector_out(det2), .current_state(cs2),
        .next_state(ns2), .match_count(mc2));

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Longest pattern prefix that is a suffix of the accepted bits.
    function automatic int best(input int q[$]);
        int n = q.size();
        int b = 0;
        for (int k = 1; k <= W; k++) begin
            bit ok = (k <= n);
            for (int i = 0; i < k && ok; i++)
                if (q[n - k + i] != int'(pat_m[W - 1 - i])) ok = 0;
            if (ok) b = k;
        end
        return b;
    endfunction

    task automatic check_outputs();
        check("current_state", current_state, ms);
        check("detector_out", detector_out, ms == W);
        check("match_count", match_count, CNT_EN ? c8 : 0);
        check("state_cntw2", cs2, ms);
        check("match_count_cntw2", mc2, CNT_EN ? c2 : 0);
    endtask

    task automatic step(input bit v, input bit b, input bit ov, input bit ld, input logic [W-1:0] pin, input bit clr);
        int q2[$];
        int pred;
        @(negedge clock);
        sequence_valid = v; sequence_in = b; overlap_en = ov;
        pattern_load = ld; pattern_in = pin; count_clear = clr;
        #1;
        q2 = mq;
        if (ms == W && !ov) q2.delete();
        q2.push_back(int'(b));
        if (q2.size() > W) void'(q2.pop_front());
        pred = v ? best(q2) : ms;
        check("next_state", next_state, pred);
        @(posedge clock);
        if (ld) begin
            pat_m = pin; mq.delete(); ms = 0;
        end else if (v) begin
            mq = q2; ms = pred;
        end
        if (clr) begin
            c8 = 0; c2 = 0;
        end else if (v && !ld && pred == W) begin
            if (c8 < 255) c8++;
            if (c2 < 3) c2++;
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        sequence_valid = 0; pattern_load = 0; count_clear = 0;
        #1;
        pat_m = DEF; mq.delete(); ms = 0; c8 = 0; c2 = 0;
        check_outputs();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic run_bits(input logic [15:0] bits, input int n, input bit ov);
        for (int i = n - 1; i >= 0; i--) step(1, bits[i], ov, 0, '0, 0);
    endtask

    initial begin
        do_reset();
        run_bits(16'b1011011, 7, 1);
        check("plan_overlap_count", match_count, CNT_EN ? 2 : 0);
        do_reset();
        run_bits(16'b1011011, 7, 0);
        check("plan_nonoverlap_state", current_state, 1);
        do_reset();
        step(1, 0, 1, 1, 4'b1111, 0);
        run_bits(16'b111111, 6, 1);
        step(0, 0, 0, 1, 4'b1111, 1);
        run_bits(16'b11111111, 8, 0);
        check("plan_ones_count", match_count, CNT_EN ? 2 : 0);
        do_reset();
        run_bits(16'b101, 3, 1);
        for (int i = 0; i < 5; i++) step(0, 1'($urandom_range(1)), 1, 0, '0, 0);
        run_bits(16'b1, 1, 1);
        check("plan_idle_match", detector_out, 1);
        do_reset();
        run_bits(16'b101, 3, 1);
        step(0, 0, 1, 0, '0, 0);
        do_reset();
        step(0, 1, 1, 0, '0, 0);
        run_bits(16'b1, 1, 1);
        check("plan_reset_gap", current_state, 1);
        do_reset();
        run_bits(16'b101, 3, 1);
        step(1, 1, 1, 1, 4'b0110, 0);
        run_bits(16'b0110, 4, 1);
        do_reset();
        run_bits(16'b101, 3, 1);
        step(1, 1, 1, 0, '0, 1);
        check("plan_clear_priority", match_count, 0);
        do_reset();
        run_bits(16'b1011011011011011, 16, 1);
        check("plan_saturate", mc2, CNT_EN ? 3 : 0);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int r = int'($urandom_range(99));
            logic [W-1:0] p;
            p = (r < 2) ? '0 : (r < 4) ? '1 : W'($urandom);
            if (r == 50) do_reset();
            else step($urandom_range(3) != 0, 1'($urandom_range(1)), $urandom_range(3) != 0,
                      $urandom_range(39) == 0, p, $urandom_range(29) == 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
